// File: rtl/fft_pkg.sv
// Shared types, default sizes and the butterfly address helper for the FFT stage controller.
package fft_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} fft_state_t;

  localparam int DEF_LOG2N  = 10;
  localparam int DEF_RD_LAT = 1;
  localparam int DEF_BF_LAT = 8;

  // Fields sized for the largest legal transform (LOG2N = 16); callers truncate.
  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] tw;
  } bf_addr_t;

  function automatic bf_addr_t bf_addr(input int unsigned log2n,
                                       input int unsigned s,
                                       input int unsigned k);
    int unsigned half;
    int unsigned pos;
    int unsigned grp;
    int unsigned a;
    bf_addr_t    r;
    half = 32'd1 << s;
    pos  = k & (half - 32'd1);
    grp  = k >> s;
    a    = (grp << (s + 32'd1)) | pos;
    r.a  = 16'(a);
    r.b  = 16'(a + half);
    r.tw = 16'(pos << (log2n - 32'd1 - s));
    return r;
  endfunction

endpackage

// File: rtl/fft_wb_pipe.sv
// Fixed-depth delay line carrying write-back control from the read issue point; async-reset to 0.
module fft_wb_pipe #(
  parameter int W     = 1,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] sr [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign q = sr[DEPTH-1];

endmodule

// File: rtl/fft_stage_controller.sv
// In-place radix-2 DIT FFT sequencer: read/twiddle addressing plus delayed write-back.
// Optional per-stage 1/2 scaling flag enabled by defining FFT_STAGE_SCALE_EN.
module fft_stage_controller
  import fft_pkg::*;
#(
  parameter int LOG2N  = DEF_LOG2N,
  parameter int RD_LAT = DEF_RD_LAT,
  parameter int BF_LAT = DEF_BF_LAT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(LOG2N)-1:0] stage,
  output logic                     rd_en,
  output logic [LOG2N-1:0]         rd_addr_a,
  output logic [LOG2N-1:0]         rd_addr_b,
  output logic [LOG2N-2:0]         tw_addr,
  output logic                     wr_en,
  output logic [LOG2N-1:0]         wr_addr_a,
  output logic [LOG2N-1:0]         wr_addr_b,
  output logic                     wr_scale,
  output fft_state_t               dbg_state
);

  localparam int SW       = $clog2(LOG2N);
  localparam int KW       = LOG2N - 1;
  localparam int PIPE_LAT = RD_LAT + BF_LAT;
  localparam int DW       = $clog2(PIPE_LAT + 1);

  fft_state_t    state, state_n;
  logic [SW-1:0] s, s_n;
  logic [KW-1:0] k, k_n;
  logic [DW-1:0] d, d_n;
  bf_addr_t      ba;

  always_comb begin
    state_n = state;
    s_n     = s;
    k_n     = k;
    d_n     = d;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = ISSUE;
          s_n     = '0;
          k_n     = '0;
        end
      end
      ISSUE: begin
        if (k == '1) begin
          state_n = DRAIN;
          d_n     = '0;
        end else begin
          k_n = k + KW'(1);
        end
      end
      DRAIN: begin
        // Hold reads off until the last write of this stage has landed.
        if (d == DW'(PIPE_LAT - 1)) begin
          if (s == SW'(LOG2N - 1)) begin
            state_n = DONE;
          end else begin
            state_n = ISSUE;
            s_n     = s + SW'(1);
            k_n     = '0;
          end
        end else begin
          d_n = d + DW'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
        s_n     = '0;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb ba = bf_addr(32'(LOG2N), 32'(s), 32'(k));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      s         <= '0;
      k         <= '0;
      d         <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_addr   <= '0;
    end else begin
      state     <= state_n;
      s         <= s_n;
      k         <= k_n;
      d         <= d_n;
      busy      <= (state_n == ISSUE) || (state_n == DRAIN);
      done      <= (state_n == DONE);
      // Read strobe/addresses follow the counters one edge later.
      rd_en     <= (state == ISSUE);
      rd_addr_a <= ba.a[LOG2N-1:0];
      rd_addr_b <= ba.b[LOG2N-1:0];
      tw_addr   <= ba.tw[LOG2N-2:0];
    end
  end

  assign stage     = s;
  assign dbg_state = state;

`ifdef FFT_STAGE_SCALE_EN
  localparam int PW = 2 * LOG2N + 2;
  logic [PW-1:0] pipe_in, pipe_out;
  assign pipe_in = {rd_en, rd_addr_a, rd_addr_b, rd_en};
  assign {wr_en, wr_addr_a, wr_addr_b, wr_scale} = pipe_out;
`else
  localparam int PW = 2 * LOG2N + 1;
  logic [PW-1:0] pipe_in, pipe_out;
  assign pipe_in = {rd_en, rd_addr_a, rd_addr_b};
  assign {wr_en, wr_addr_a, wr_addr_b} = pipe_out;
  assign wr_scale = 1'b0;
`endif

  fft_wb_pipe #(
    .W     (PW),
    .DEPTH (PIPE_LAT)
  ) u_wb_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pipe_in),
    .q     (pipe_out)
  );

endmodule

// File: tb/tb_fft_stage_controller.sv
// Directed bench for fft_stage_controller at LOG2N=3, RD_LAT=1, BF_LAT=8.
module tb_fft_stage_controller;
  import fft_pkg::*;

  localparam int LOG2N = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       busy, done, rd_en, wr_en, wr_scale;
  logic [1:0] stage;
  logic [2:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [1:0] tw_addr;
  fft_state_t dbg_state;

  fft_stage_controller #(.LOG2N(3), .RD_LAT(1), .BF_LAT(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .stage(stage), .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .tw_addr(tw_addr), .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
    .wr_scale(wr_scale), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Hand-computed read schedule: stages 0,1,2 x butterflies 0..3.
  int tab_a  [12] = '{0, 2, 4, 6,  0, 1, 4, 5,  0, 1, 2, 3};
  int tab_b  [12] = '{1, 3, 5, 7,  2, 3, 6, 7,  4, 5, 6, 7};
  int tab_tw [12] = '{0, 0, 0, 0,  0, 2, 0, 2,  0, 1, 2, 3};

  logic [5:0] exp_q [$];
  int         res_a_q [$];
  int         res_b_q [$];
  int         ram [8];
  int         rd_cnt, wr_cnt;

`ifdef FFT_STAGE_SCALE_EN
  localparam int BIN_EXP = 8;
`else
  localparam int BIN_EXP = 64;
`endif

  task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s@%0d observed=%0h expected=%0h", tag, c, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    exp_q.delete();
    res_a_q.delete();
    res_b_q.delete();
    for (int i = 0; i < 8; i++) ram[i] = 0;
    ram[0] = 64;
    rd_cnt = 0;
    wr_cnt = 0;
  endtask

  task automatic chk_all_zero(input int c);
    chk("rst_busy", c, 32'(busy), 0);
    chk("rst_done", c, 32'(done), 0);
    chk("rst_stage", c, 32'(stage), 0);
    chk("rst_rd_en", c, 32'(rd_en), 0);
    chk("rst_rd_a", c, 32'(rd_addr_a), 0);
    chk("rst_rd_b", c, 32'(rd_addr_b), 0);
    chk("rst_tw", c, 32'(tw_addr), 0);
    chk("rst_wr_en", c, 32'(wr_en), 0);
    chk("rst_wr_a", c, 32'(wr_addr_a), 0);
    chk("rst_wr_b", c, 32'(wr_addr_b), 0);
    chk("rst_wr_scale", c, 32'(wr_scale), 0);
    chk("rst_state", c, 32'(dbg_state), 32'(IDLE));
  endtask

  function automatic fft_state_t exp_state(input int c);
    if (c >= 41) return IDLE;
    if (c == 40) return DONE;
    return (((c - 1) % 13) < 4) ? ISSUE : DRAIN;
  endfunction

  function automatic int exp_stage(input int c);
    if (c >= 41) return 0;
    if (c == 40) return 2;
    return (c - 1) / 13;
  endfunction

  // Start one transform (start accepted in cycle 0) and check every cycle up to last_c.
  task automatic run_check(input int last_c, input bit poke);
    int  ri, wi, hit;
    logic [5:0] pend;
    model_clear();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= last_c; c++) begin
      ri = -1;
      wi = -1;
      for (int st = 0; st < 3; st++)
        for (int j = 0; j < 4; j++) begin
          if (c == 2 + 13 * st + j)  ri = 4 * st + j;
          if (c == 11 + 13 * st + j) wi = 4 * st + j;
        end
      chk("busy", c, 32'(busy), 32'(c <= 39));
      chk("done", c, 32'(done), 32'(c == 40));
      chk("stage", c, 32'(stage), 32'(exp_stage(c)));
      chk("state", c, 32'(dbg_state), 32'(exp_state(c)));
      chk("rd_en", c, 32'(rd_en), 32'(ri >= 0));
      chk("wr_en", c, 32'(wr_en), 32'(wi >= 0));
`ifdef FFT_STAGE_SCALE_EN
      chk("wr_scale", c, 32'(wr_scale), 32'(wi >= 0));
`else
      chk("wr_scale", c, 32'(wr_scale), 0);
`endif
      if (ri >= 0) begin
        chk("rd_a", c, 32'(rd_addr_a), 32'(tab_a[ri]));
        chk("rd_b", c, 32'(rd_addr_b), 32'(tab_b[ri]));
        chk("tw", c, 32'(tw_addr), 32'(tab_tw[ri]));
      end
      if (wi >= 0) begin
        chk("wr_a", c, 32'(wr_addr_a), 32'(tab_a[wi]));
        chk("wr_b", c, 32'(wr_addr_b), 32'(tab_b[wi]));
      end
      // Scoreboard: writes must replay reads in order; butterfly model tracks RAM contents.
      if (wr_en === 1'b1) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          chk("wb_unexpected", c, 1, 0);
        end else begin
          pend = exp_q.pop_front();
          chk("wb_pair", c, 32'({wr_addr_a, wr_addr_b}), 32'(pend));
          ram[wr_addr_a] = (wr_scale === 1'b1) ? (res_a_q[0] >>> 1) : res_a_q[0];
          ram[wr_addr_b] = (wr_scale === 1'b1) ? (res_b_q[0] >>> 1) : res_b_q[0];
          void'(res_a_q.pop_front());
          void'(res_b_q.pop_front());
        end
      end
      if (rd_en === 1'b1) begin
        rd_cnt++;
        hit = 0;
        foreach (exp_q[i])
          if (exp_q[i][5:3] == rd_addr_a || exp_q[i][5:3] == rd_addr_b ||
              exp_q[i][2:0] == rd_addr_a || exp_q[i][2:0] == rd_addr_b) hit = 1;
        chk("hazard", c, 32'(hit), 0);
        exp_q.push_back({rd_addr_a, rd_addr_b});
        res_a_q.push_back(ram[rd_addr_a] + ram[rd_addr_b]);
        res_b_q.push_back(ram[rd_addr_a] - ram[rd_addr_b]);
      end
      start = poke && (c == 5 || c == 20);
      if (c < last_c) tick();
    end
    start = 1'b0;
    if (last_c >= 41) begin
      chk("rd_count", last_c, 32'(rd_cnt), 12);
      chk("wr_count", last_c, 32'(wr_cnt), 12);
      chk("wb_left", last_c, 32'(exp_q.size()), 0);
      for (int i = 0; i < 8; i++) chk($sformatf("bin%0d", i), last_c, 32'(ram[i]), 32'(BIN_EXP));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    #12;
    chk_all_zero(-1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    chk("idle_busy", 0, 32'(busy), 0);

    // Plain transform.
    run_check(41, 1'b0);
    // Start two cycles after done, with ignored starts mid-transform.
    tick();
    run_check(41, 1'b1);

    // Async reset during stage 1 drain while writes are still in flight.
    tick();
    run_check(20, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_all_zero(20);
    model_clear();
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 15; c++) begin
      tick();
      chk("post_rst_wr_en", c, 32'(wr_en), 0);
      chk("post_rst_rd_en", c, 32'(rd_en), 0);
      chk("post_rst_busy", c, 32'(busy), 0);
    end
    run_check(41, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
